// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_gen : raster counters, sync pulses, valid flag and frame tick.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FRONT  = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BACK   = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FRONT  = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BACK   = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] col,
   output logic [9:0] row,
   output logic       valid,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_tick,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] c_h_front = 10'(H_ACTIVE);
   localparam logic [9:0] c_h_sync  = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] c_h_back  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [9:0] c_h_last  = 10'(H_TOTAL - 1);
   localparam logic [9:0] c_v_front = 10'(V_ACTIVE);
   localparam logic [9:0] c_v_sync  = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] c_v_back  = 10'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [9:0] c_v_last  = 10'(V_TOTAL - 1);

   generate
      if (H_TOTAL > 1024) begin : g_h_width_check
         $error("vga_timing_gen: H_TOTAL %0d exceeds 1024", H_TOTAL);
      end
      if (V_TOTAL > 1024) begin : g_v_width_check
         $error("vga_timing_gen: V_TOTAL %0d exceeds 1024", V_TOTAL);
      end
   endgenerate

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_e;

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   phase_e     h_phase_q, h_phase_d;
   phase_e     v_phase_q, v_phase_d;
   logic       w_h_wrap;
   logic       w_frame_start;

   logic [9:0] col_q, row_q;
   logic       valid_q, hsync_q, vsync_q, frame_tick_q;
   logic [7:0] frame_count_q;

   // Phase is a function of the counter value it will describe; later boundaries win
   // so that zero-length porches collapse cleanly.
   function automatic phase_e next_phase(input phase_e     cur,
                                         input logic [9:0] cnt,
                                         input logic [9:0] front,
                                         input logic [9:0] sync,
                                         input logic [9:0] back);
      phase_e nxt;
      nxt = cur;
      if (cnt == 10'd0)       nxt = PH_ACTIVE;
      else if (cnt == back)   nxt = PH_BACK;
      else if (cnt == sync)   nxt = PH_SYNC;
      else if (cnt == front)  nxt = PH_FRONT;
      return nxt;
   endfunction

   always_comb begin
      w_h_wrap      = (h_cnt_q == c_h_last);
      h_cnt_d       = w_h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      v_cnt_d       = v_cnt_q;
      v_phase_d     = v_phase_q;
      if (w_h_wrap) begin
         v_cnt_d   = (v_cnt_q == c_v_last) ? 10'd0 : v_cnt_q + 10'd1;
         v_phase_d = next_phase(v_phase_q, v_cnt_d, c_v_front, c_v_sync, c_v_back);
      end
      h_phase_d     = next_phase(h_phase_q, h_cnt_d, c_h_front, c_h_sync, c_h_back);
      w_frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == c_v_front);
   end

   // Outputs sample the counter/phase state of the current pixel, so they lag the
   // counters by one edge and stay mutually aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q       <= 10'd0;
         v_cnt_q       <= 10'd0;
         h_phase_q     <= PH_ACTIVE;
         v_phase_q     <= PH_ACTIVE;
         col_q         <= 10'd0;
         row_q         <= 10'd0;
         valid_q       <= 1'b0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         frame_tick_q  <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         h_phase_q     <= h_phase_d;
         v_phase_q     <= v_phase_d;
         col_q         <= h_cnt_q;
         row_q         <= v_cnt_q;
         valid_q       <= (h_phase_q == PH_ACTIVE) && (v_phase_q == PH_ACTIVE);
         hsync_q       <= (h_phase_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         vsync_q       <= (v_phase_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         frame_tick_q  <= w_frame_start;
         if (w_frame_start) begin
            frame_count_q <= frame_count_q + 8'd1;
         end
      end
   end

   assign col         = col_q;
   assign row         = row_q;
   assign valid       = valid_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_tick  = frame_tick_q;
   assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_timing_gen : directed checks on a default-timing and a tiny raster. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [9:0] d_col, d_row;
   logic       d_valid, d_hs, d_vs, d_tick;
   logic [7:0] d_cnt;
   logic [9:0] s_col, s_row;
   logic       s_valid, s_hs, s_vs, s_tick;
   logic [7:0] s_cnt;

   int checks = 0;
   int errors = 0;

   vga_timing_gen dut_def (
      .clk(clk), .rst(rst), .col(d_col), .row(d_row), .valid(d_valid),
      .hsync(d_hs), .vsync(d_vs), .frame_tick(d_tick), .frame_count(d_cnt)
   );

   // Tiny raster: 15 columns (8 active, sync 10..12), 8 rows (4 active, sync 5..6)
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0)
   ) dut_sm (
      .clk(clk), .rst(rst), .col(s_col), .row(s_row), .valid(s_valid),
      .hsync(s_hs), .vsync(s_vs), .frame_tick(s_tick), .frame_count(s_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({d_col, d_row, d_valid, d_hs, d_vs, d_tick, d_cnt} !==
          {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL reset_def got col=%0d row=%0d v=%b hs=%b vs=%b t=%b n=%0d want 0 0 0 1 1 0 0",
                  d_col, d_row, d_valid, d_hs, d_vs, d_tick, d_cnt);
      end
      checks++;
      if ({s_col, s_row, s_valid, s_hs, s_vs, s_tick, s_cnt} !==
          {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL reset_sm got col=%0d row=%0d v=%b hs=%b vs=%b t=%b n=%0d want 0 0 0 1 1 0 0",
                  s_col, s_row, s_valid, s_hs, s_vs, s_tick, s_cnt);
      end
   endtask

   task automatic test_first_line();
      int hs_low, hs_first, hs_last, pos_err, vs_low;
      hs_low = 0; hs_first = -1; hs_last = -1; pos_err = 0; vs_low = 0;
      apply_reset();
      for (int k = 1; k <= 1600; k++) begin
         step();
         if (d_col !== 10'((k - 1) % 800) || d_row !== 10'((k - 1) / 800)) pos_err++;
         if (d_vs !== 1'b1) vs_low++;
         if (k <= 800 && d_hs === 1'b0) begin
            hs_low++;
            if (hs_first < 0) hs_first = int'(d_col);
            hs_last = int'(d_col);
         end
         if (k == 1) begin
            checks++;
            if ({d_col, d_row, d_valid, d_hs, d_vs} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
               errors++;
               $display("FAIL first_edge got col=%0d row=%0d v=%b hs=%b vs=%b want 0 0 1 1 1",
                        d_col, d_row, d_valid, d_hs, d_vs);
            end
         end
         if (k == 640) begin
            checks++;
            if ({d_col, d_valid} !== {10'd639, 1'b1}) begin
               errors++;
               $display("FAIL last_active got col=%0d v=%b want 639 1", d_col, d_valid);
            end
         end
         if (k == 641) begin
            checks++;
            if ({d_col, d_valid} !== {10'd640, 1'b0}) begin
               errors++;
               $display("FAIL first_blank got col=%0d v=%b want 640 0", d_col, d_valid);
            end
         end
         if (k == 801) begin
            checks++;
            if ({d_col, d_row, d_valid} !== {10'd0, 10'd1, 1'b1}) begin
               errors++;
               $display("FAIL line_wrap got col=%0d row=%0d v=%b want 0 1 1", d_col, d_row, d_valid);
            end
         end
      end
      checks++;
      if (hs_low != 96) begin errors++; $display("FAIL hsync_width got %0d want 96", hs_low); end
      checks++;
      if (hs_first != 656) begin errors++; $display("FAIL hsync_start got %0d want 656", hs_first); end
      checks++;
      if (hs_last != 751) begin errors++; $display("FAIL hsync_end got %0d want 751", hs_last); end
      checks++;
      if (pos_err != 0) begin errors++; $display("FAIL def_position got %0d bad cycles want 0", pos_err); end
      checks++;
      if (vs_low != 0) begin errors++; $display("FAIL def_vsync_idle got %0d low cycles want 0", vs_low); end
   endtask

   task automatic test_frames();
      int e_pos, e_valid, e_hs, e_vs, e_tick, e_cnt, vs_low0, val0, ticks, exp_cnt;
      int tick_k[3];
      logic [7:0] tick_n[3];
      e_pos = 0; e_valid = 0; e_hs = 0; e_vs = 0; e_tick = 0; e_cnt = 0;
      vs_low0 = 0; val0 = 0; ticks = 0; exp_cnt = 0;
      for (int i = 0; i < 3; i++) begin tick_k[i] = 0; tick_n[i] = 8'd0; end
      apply_reset();
      for (int k = 1; k <= 360; k++) begin
         int p, c, r;
         logic ev, eh, evs, et;
         step();
         p = k - 1; c = p % 15; r = (p / 15) % 8;
         ev  = (c < 8) && (r < 4);
         eh  = !((c >= 10) && (c < 13));
         evs = !((r >= 5) && (r < 7));
         et  = (c == 0) && (r == 4);
         if (et) exp_cnt++;
         if (s_col !== 10'(c) || s_row !== 10'(r)) e_pos++;
         if (s_valid !== ev) e_valid++;
         if (s_hs !== eh) e_hs++;
         if (s_vs !== evs) e_vs++;
         if (s_tick !== et) e_tick++;
         if (s_cnt !== 8'(exp_cnt)) e_cnt++;
         if (k <= 120 && s_vs === 1'b0) vs_low0++;
         if (k <= 120 && s_valid === 1'b1) val0++;
         if (s_tick === 1'b1) begin
            if (ticks < 3) begin tick_k[ticks] = k; tick_n[ticks] = s_cnt; end
            ticks++;
         end
         if (k == 120 || k == 121) begin
            checks++;
            if ({s_col, s_row} !== ((k == 120) ? {10'd14, 10'd7} : {10'd0, 10'd0})) begin
               errors++;
               $display("FAIL frame_wrap_k%0d got col=%0d row=%0d", k, s_col, s_row);
            end
         end
      end
      checks++;
      if (e_pos != 0) begin errors++; $display("FAIL sm_position got %0d bad want 0", e_pos); end
      checks++;
      if (e_valid != 0) begin errors++; $display("FAIL sm_valid got %0d bad want 0", e_valid); end
      checks++;
      if (e_hs != 0) begin errors++; $display("FAIL sm_hsync got %0d bad want 0", e_hs); end
      checks++;
      if (e_vs != 0) begin errors++; $display("FAIL sm_vsync got %0d bad want 0", e_vs); end
      checks++;
      if (e_tick != 0) begin errors++; $display("FAIL sm_tick got %0d bad want 0", e_tick); end
      checks++;
      if (e_cnt != 0) begin errors++; $display("FAIL sm_count got %0d bad want 0", e_cnt); end
      checks++;
      if (vs_low0 != 30) begin errors++; $display("FAIL vsync_width got %0d want 30", vs_low0); end
      checks++;
      if (val0 != 32) begin errors++; $display("FAIL valid_per_frame got %0d want 32", val0); end
      checks++;
      if (ticks != 3 || tick_k[0] != 61 || tick_k[1] - tick_k[0] != 120 || tick_k[2] - tick_k[1] != 120) begin
         errors++;
         $display("FAIL tick_spacing got n=%0d at %0d %0d %0d want 3 at 61 181 301",
                  ticks, tick_k[0], tick_k[1], tick_k[2]);
      end
      checks++;
      if ({tick_n[0], tick_n[1], tick_n[2]} !== {8'd1, 8'd2, 8'd3}) begin
         errors++;
         $display("FAIL tick_counts got %0d %0d %0d want 1 2 3", tick_n[0], tick_n[1], tick_n[2]);
      end
   endtask

   task automatic test_reset_midframe();
      apply_reset();
      repeat (87) step();
      checks++;
      if ({s_col, s_row, s_hs, s_vs, s_cnt} !== {10'd11, 10'd5, 1'b0, 1'b0, 8'd1}) begin
         errors++;
         $display("FAIL midframe_pre got col=%0d row=%0d hs=%b vs=%b n=%0d want 11 5 0 0 1",
                  s_col, s_row, s_hs, s_vs, s_cnt);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({s_col, s_row, s_valid, s_hs, s_vs, s_cnt} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 8'd0}) begin
         errors++;
         $display("FAIL async_reset got col=%0d row=%0d v=%b hs=%b vs=%b n=%0d want 0 0 0 1 1 0",
                  s_col, s_row, s_valid, s_hs, s_vs, s_cnt);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step();
      checks++;
      if ({s_col, s_row, s_valid, s_hs, s_vs} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL restart got col=%0d row=%0d v=%b hs=%b vs=%b want 0 0 1 1 1",
                  s_col, s_row, s_valid, s_hs, s_vs);
      end
      step();
      checks++;
      if (s_col !== 10'd1) begin errors++; $display("FAIL restart_advance got col=%0d want 1", s_col); end
   endtask

   task automatic test_count_wrap();
      int ticks, bad;
      logic [7:0] n255, n256;
      ticks = 0; bad = 0; n255 = 8'hxx; n256 = 8'hxx;
      apply_reset();
      for (int k = 1; k <= 30720; k++) begin
         step();
         if (s_tick === 1'b1) begin
            ticks++;
            if (s_cnt !== 8'(ticks % 256)) bad++;
            if (ticks == 255) n255 = s_cnt;
            if (ticks == 256) n256 = s_cnt;
         end
      end
      checks++;
      if (ticks != 256) begin errors++; $display("FAIL wrap_ticks got %0d want 256", ticks); end
      checks++;
      if (n255 !== 8'd255) begin errors++; $display("FAIL count_255 got %0d want 255", n255); end
      checks++;
      if (n256 !== 8'd0) begin errors++; $display("FAIL count_wrap got %0d want 0", n256); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL count_seq got %0d bad want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_first_line();
      test_frames();
      test_reset_midframe();
      test_count_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
